// File: rtl/not_pkg.sv
// Shared constants for the not_pipe inverter pipeline.
// COUNT_W sizes the optional NOT_PIPE_COUNT_EN transfer counter.
package not_pkg;

  localparam int COUNT_W    = 16;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;

endpackage

// File: rtl/not_pipe_if.sv
// Stream bundle for not_pipe: upstream word+mask,
// downstream word, valid/ready on both sides.
interface not_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_mask,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_mask,
    output out_valid,
    input  out_ready,
    output out_data
  );

endinterface

// File: rtl/not_pipe_stage.sv
// One elastic register stage: loads when empty
// or when the downstream side takes its word.
module not_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;
  logic             w_adv;

  assign w_adv = !r_v || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (w_adv) begin
      r_v <= i_valid;
      if (i_valid) r_d <= i_data;
    end
  end

  assign o_valid = r_v;
  assign o_data  = r_d;

endmodule

// File: rtl/not_pipe.sv
// Masked bitwise inverter over an elastic STAGES-deep pipe.
// Define NOT_PIPE_COUNT_EN to add the xfer_count/clr_count ports.
module not_pipe
  import not_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef NOT_PIPE_COUNT_EN
  input  logic               clr_count,
  output logic [COUNT_W-1:0] xfer_count,
`endif
  not_pipe_if.slave          bus
);

  logic [WIDTH-1:0]  w_x;
  logic [STAGES-1:0] w_sv;
  logic [WIDTH-1:0]  w_sd [STAGES];
  logic [STAGES:0]   w_rdy;

  assign w_x = bus.in_data ^ bus.in_mask;

  // Ready ripples from the output back to the input
  always_comb begin
    w_rdy = '0;
    w_rdy[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = !w_sv[k] || w_rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic             w_iv;
    logic [WIDTH-1:0] w_id;
    if (k == 0) begin : g_head
      assign w_iv = bus.in_valid;
      assign w_id = w_x;
    end else begin : g_body
      assign w_iv = w_sv[k-1];
      assign w_id = w_sd[k-1];
    end
    not_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_iv),
      .i_data  (w_id),
      .i_ready (w_rdy[k+1]),
      .o_valid (w_sv[k]),
      .o_data  (w_sd[k])
    );
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = w_sv[STAGES-1];
  assign bus.out_data  = w_sd[STAGES-1];

`ifdef NOT_PIPE_COUNT_EN
  logic               w_xfer;
  logic [COUNT_W-1:0] r_cnt;

  assign w_xfer = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_count) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign xfer_count = r_cnt;
`endif

endmodule

// File: tb/tb_not_pipe.sv
// Directed bench for not_pipe (WIDTH=8, STAGES=2).
// Counter checks run when NOT_PIPE_COUNT_EN is defined.
module tb_not_pipe;
  import not_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int S = DEF_STAGES;

  logic clk;
  logic rst_n;
`ifdef NOT_PIPE_COUNT_EN
  logic               clr_count;
  logic [COUNT_W-1:0] xfer_count;
`endif

  not_pipe_if #(.WIDTH(W)) bus ();

  not_pipe #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef NOT_PIPE_COUNT_EN
    .clr_count  (clr_count),
    .xfer_count (xfer_count),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [W-1:0] got  [$];
  int           gcyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer seen at negedge happens on the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_data);
      gcyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d,
                      input logic [W-1:0] m);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mask  = m;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.in_mask   = 8'h00;
    bus.out_ready = 1'b1;
`ifdef NOT_PIPE_COUNT_EN
    clr_count = 1'b0;
`endif

    repeat (3) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 1);
    chk("rel_out_valid", 32'(bus.out_valid), 0);
`ifdef NOT_PIPE_COUNT_EN
    chk("rst_count", 32'(xfer_count), 0);
`endif

    send(8'hA5, 8'hFF);
    chk("a5_not_yet", 32'(bus.out_valid), 0);
    tick();
    chk("a5_valid", 32'(bus.out_valid), 1);
    chk("a5_data", 32'(bus.out_data), 32'h5A);
    tick();
    chk("a5_gone", 32'(bus.out_valid), 0);

    send(8'h0F, 8'h00);
    tick();
    chk("0f_data", 32'(bus.out_data), 32'h0F);

    send(8'hF0, 8'h3C);
    tick();
    chk("f0_data", 32'(bus.out_data), 32'hCC);
    tick();

    got.delete();
    gcyc.delete();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("strm_rdy%0d", i),
          32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      bus.in_mask  = 8'hFF;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("strm_count", 32'(got.size()), 16);
    if (got.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("strm_d%0d", i),
            32'(got[i]), 32'(8'hFF - 8'(i)));
      end
      chk("strm_nogap", 32'(gcyc[15] - gcyc[0]), 15);
    end

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.in_mask   = 8'hFF;
    tick();
    bus.in_data   = 8'h22;
    bus.in_mask   = 8'h00;
    tick();
    bus.in_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_rdy%0d", i),
          32'(bus.in_ready), 0);
      chk($sformatf("bp_vld%0d", i),
          32'(bus.out_valid), 1);
      chk($sformatf("bp_dat%0d", i),
          32'(bus.out_data), 32'hEE);
      tick();
    end
    got.delete();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_back", 32'(bus.in_ready), 1);
    repeat (3) tick();
    chk("bp_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("bp_w0", 32'(got[0]), 32'hEE);
      chk("bp_w1", 32'(got[1]), 32'h22);
    end

    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    bus.in_mask  = 8'h00;
    tick();
    bus.in_data  = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    chk("mr_full", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_vld_drop", 32'(bus.out_valid), 0);
    chk("mr_dat_clr", 32'(bus.out_data), 0);
    got.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mr_no_stale", 32'(got.size()), 0);
    chk("mr_out_valid", 32'(bus.out_valid), 0);

`ifdef NOT_PIPE_COUNT_EN
    chk("cnt_after_rst", 32'(xfer_count), 0);
    bus.in_valid = 1'b1;
    bus.in_mask  = 8'h00;
    for (int i = 0; i < 65537; i++) begin
      bus.in_data = 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    got.delete();
    gcyc.delete();
    chk("cnt_wrap", 32'(xfer_count), 1);

    send(8'h99, 8'h00);
    tick();
    chk("clr_vld", 32'(bus.out_valid), 1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr_prio", 32'(xfer_count), 0);
    send(8'h98, 8'h00);
    repeat (2) tick();
    chk("cnt_after_clr", 32'(xfer_count), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
